// File: rtl/uart_port_pkg.sv
// rexta: shared register map, STATUS bit positions and serializer state type
// for the uart_port peripheral.
package rexta;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;

  localparam int STAT_TX_FULL     = 0;
  localparam int STAT_TX_IDLE     = 1;
  localparam int STAT_TX_OVERFLOW = 2;
  localparam int STAT_RX_VALID    = 3;
  localparam int STAT_RX_OVERRUN  = 4;
  localparam int STAT_COUNT_LSB   = 8;

  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_tx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int uart_divisor(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with first-word fall-through read data.
// Pushes while full and pops while empty are ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_port.sv
// uart_port: memory-mapped 8N1 UART slave with a TX FIFO and serializer.
// Define UART_RX_EN to build the receiver; otherwise rx is ignored and RX fields read 0.
module uart_port
  import rexta::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        tx,
  input  logic        rx
);

  localparam int DIVISOR = uart_divisor(CLK_HZ, BAUD);
  localparam int CNT_W   = $clog2(DIVISOR + 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(DIVISOR / 2 - 1);

  // ---------------- bus decode ----------------
  logic        accept;
  logic [1:0]  reg_sel;
  logic        push;
  logic        data_rd;
  logic        status_rd;
  logic [31:0] rd_mux;

  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [7:0]                    fifo_dout;
  logic                          tx_load;

  logic       tx_overflow;
  logic       rx_valid;
  logic       rx_overrun;
  logic [7:0] rx_byte;

  uart_tx_state_t tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;

  // cs is ignored while ready is high, so each access takes two cycles.
  assign accept    = cs && !ready;
  assign reg_sel   = addr[3:2];
  assign push      = accept && we && (reg_sel == UART_REG_DATA);
  assign data_rd   = accept && !we && (reg_sel == UART_REG_DATA);
  assign status_rd = accept && !we && (reg_sel == UART_REG_STATUS);

  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:8]};

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = '0;
    case (reg_sel)
      UART_REG_DATA: rd_mux = {24'b0, rx_byte};
      UART_REG_STATUS: begin
        rd_mux[STAT_TX_FULL]           = fifo_full;
        rd_mux[STAT_TX_IDLE]           = fifo_empty && (tx_state == UART_IDLE);
        rd_mux[STAT_TX_OVERFLOW]       = tx_overflow;
        rd_mux[STAT_RX_VALID]          = rx_valid;
        rd_mux[STAT_RX_OVERRUN]        = rx_overrun;
        rd_mux[STAT_COUNT_LSB +: 4]    = 4'(fifo_count);
      end
      UART_REG_DIV: rd_mux = 32'(DIVISOR);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready       <= 1'b0;
      rdata       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      ready <= accept;
      rdata <= (accept && !we) ? rd_mux : '0;
      // Full is judged before this edge's pop, so a push to a full FIFO is always lost.
      if (push && fifo_full)  tx_overflow <= 1'b1;
      else if (status_rd)     tx_overflow <= 1'b0;
    end
  end

  // ---------------- TX FIFO ----------------
  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (wdata[7:0]),
    .pop       (tx_load),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------- serializer ----------------
  // A byte is loaded from IDLE, or at the end of STOP for back-to-back frames.
  assign tx_load = !fifo_empty &&
                   ((tx_state == UART_IDLE) || ((tx_state == UART_STOP) && (tx_cnt == '0)));

  // tx is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= UART_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        UART_IDLE: begin
          tx <= 1'b1;
          if (tx_load) begin
            tx_shift <= fifo_dout;
            tx_cnt   <= BIT_RELOAD;
            tx_state <= UART_START;
          end
        end
        UART_START: begin
          tx <= 1'b0;
          if (tx_cnt == '0) begin
            tx_cnt   <= BIT_RELOAD;
            tx_bit   <= '0;
            tx_state <= UART_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        UART_DATA: begin
          tx <= tx_shift[0];
          if (tx_cnt == '0) begin
            tx_cnt   <= BIT_RELOAD;
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_state <= UART_STOP;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        UART_STOP: begin
          tx <= 1'b1;
          if (tx_cnt == '0) begin
            if (tx_load) begin
              tx_shift <= fifo_dout;
              tx_cnt   <= BIT_RELOAD;
              tx_state <= UART_START;
            end else begin
              tx_state <= UART_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= UART_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
`ifdef UART_RX_EN
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  uart_tx_state_t   rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= UART_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      // Bus clears come first so a completing byte in the same cycle wins.
      if (data_rd)   rx_valid   <= 1'b0;
      if (status_rd) rx_overrun <= 1'b0;
      case (rx_state)
        UART_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= HALF_RELOAD;
            rx_state <= UART_START;
          end
        end
        UART_START: begin
          if (rx_cnt == '0) begin
            if (!rx_s2) begin
              rx_cnt   <= BIT_RELOAD;
              rx_bit   <= '0;
              rx_state <= UART_DATA;
            end else begin
              rx_state <= UART_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        UART_DATA: begin
          if (rx_cnt == '0) begin
            rx_cnt   <= BIT_RELOAD;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= UART_STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        UART_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= UART_IDLE;
            if (rx_s2) begin
              if (rx_valid && !data_rd) begin
                rx_overrun <= 1'b1;
              end else begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
              end
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= UART_IDLE;
      endcase
    end
  end
`else
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_byte    = '0;

  logic unused_rx;
  assign unused_rx = rx ^ data_rd;
`endif

endmodule
